// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan controller:
//   - segment patterns {g,f,e,d,c,b,a}, active-high
//   - display FSM state encoding
//   - bcd_digits(): number of decimal digits needed for a WIDTH-bit value
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        CONV  = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // Decimal digit count of 2^width-1, i.e. ceil(width*log10(2)).
    // 2^width is never a power of ten, so the ceiling is exact; the
    // 5-digit log10(2) approximation is good far beyond practical widths.
    // Gives 5 for width=16 (65535). The converter's top digit is
    // zero-extended to a full nibble.
    function automatic int bcd_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// ---------------------------------------------------------------------------
// bin2bcd
// Combinational binary -> packed BCD converter (shift-and-add-3).
// Ports:
//   i_bin  in  WIDTH     unsigned binary
//   o_bcd  out 4*DIGITS  packed BCD, digit 0 in bits [3:0]
// ---------------------------------------------------------------------------
module bin2bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic [WIDTH-1:0]    i_bin,
    output logic [4*DIGITS-1:0] o_bcd
);

    logic [4*DIGITS+WIDTH-1:0] w_sr;

    always_comb begin
        w_sr = {{(4*DIGITS){1'b0}}, i_bin};
        for (int i = 0; i < WIDTH; i++) begin
            // Any digit >= 5 would carry past 9 after the doubling shift.
            for (int d = 0; d < DIGITS; d++) begin
                if (w_sr[WIDTH+4*d +: 4] >= 4'd5)
                    w_sr[WIDTH+4*d +: 4] = w_sr[WIDTH+4*d +: 4] + 4'd3;
            end
            w_sr = w_sr << 1;
        end
        o_bcd = w_sr[WIDTH +: 4*DIGITS];
    end

endmodule

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational BCD nibble -> segment pattern. Non-decimal nibbles show a
// dash as a converter fault indicator.
// Ports:
//   i_nib  in  4  BCD nibble
//   o_seg  out 7  {g,f,e,d,c,b,a}, active-high
// ---------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_nib)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Multiplexed common-anode 7-segment display controller. A value accepted
// on the valid/ready handshake is converted to BCD in one cycle, latched
// atomically, and scanned one digit per SCAN_DIV-cycle slot. The first
// BLANK_CYC cycles of each slot drive all anodes off to avoid ghosting.
//
// Optional feature: define SEG7_LZB_EN for leading-zero blanking (digits
// above the most significant nonzero digit show no segments; digit 0 is
// always shown; anodes still strobe for uniform brightness).
//
// Ports:
//   clk       in   1       system clock
//   rst_n     in   1       async active-low reset
//   in_valid  in   1       producer has a value
//   in_ready  out  1       controller can accept (low only during CONV)
//   in_data   in   WIDTH   unsigned binary value
//   seg       out  7       {g,f,e,d,c,b,a}, active-high
//   an        out  DIGITS  digit enables, active-low, an[0] = LS digit
//   busy      out  1       conversion in flight
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int SCAN_DIV  = 27000,
    parameter int BLANK_CYC = 2,
    localparam int DIGITS   = bcd_digits(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              busy
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] TC_P     = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_P  = PW'(BLANK_CYC);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    state_t              r_state;
    logic [WIDTH-1:0]    r_in;
    logic [4*DIGITS-1:0] r_dig;
    logic                r_disp_on;   // digit register holds a real value
    logic [PW-1:0]       r_pre;
    logic [IW-1:0]       r_idx;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;
    logic                r_ready;
    logic                r_busy;

    logic [4*DIGITS-1:0] w_bcd;
    logic [3:0]          w_nib;
    logic [6:0]          w_dec;
    logic                w_slot_on;
    logic                w_lz_hit;
    logic [DIGITS-1:0]   w_an_on;

    bin2bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_b2b (
        .i_bin (r_in),
        .o_bcd (w_bcd)
    );

    assign w_nib = r_dig[{r_idx, 2'b00} +: 4];

    seg7_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_dec)
    );

`ifdef SEG7_LZB_EN
    logic [DIGITS-1:0] w_lz;

    // w_lz[d] is set when digit d and every digit above it are zero.
    always_comb begin
        logic v_run;
        v_run = 1'b1;
        w_lz  = '0;
        for (int d = DIGITS - 1; d > 0; d--) begin
            v_run   = v_run & (r_dig[4*d +: 4] == 4'd0);
            w_lz[d] = v_run;
        end
    end
    assign w_lz_hit = w_lz[r_idx];
`else
    assign w_lz_hit = 1'b0;
`endif

    assign w_slot_on = r_disp_on && (r_pre >= BLANK_P);
    assign w_an_on   = ~(DIGITS'(1) << r_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= EMPTY;
            r_in      <= '0;
            r_dig     <= '0;
            r_disp_on <= 1'b0;
            r_pre     <= '0;
            r_idx     <= '0;
            r_seg     <= SEG_OFF;
            r_an      <= '1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            // Free-running scan timebase; a new value never resets it.
            if (r_pre == TC_P) begin
                r_pre <= '0;
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end

            if (w_slot_on) begin
                r_an  <= w_an_on;
                r_seg <= w_lz_hit ? SEG_OFF : w_dec;
            end else begin
                r_an  <= '1;
                r_seg <= SEG_OFF;
            end

            case (r_state)
                EMPTY, SHOW: begin
                    if (in_valid && r_ready) begin
                        r_in    <= in_data;
                        r_state <= CONV;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                CONV: begin
                    r_dig     <= w_bcd;
                    r_disp_on <= 1'b1;
                    r_state   <= SHOW;
                    r_ready   <= 1'b1;
                    r_busy    <= 1'b0;
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign in_ready = r_ready;
    assign busy     = r_busy;
    assign seg      = r_seg;
    assign an       = r_an;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int ND = 5;

`ifdef SEG7_LZB_EN
    localparam logic [6:0] Z = 7'h00;
`else
    localparam logic [6:0] Z = 7'h3F;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_data = '0;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic          busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         idx;
        logic [6:0] seg;
    } exp_t;
    exp_t sb[$];

    logic [15:0] vec_val [6];
    logic [6:0]  vec_seg [6][ND];

    seg7_scan_ctrl #(.WIDTH(16), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .seg      (seg),
        .an       (an),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: at each slot start, compare seg against the expected entry
    // for that digit index; also checks blanking while armed.
    logic [ND-1:0] prev_an = '1;
    int            blank_run = 0;
    bit            after_lit = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            after_lit = 1'b0;
            blank_run = 0;
            prev_an   = '1;
        end else begin
            if (an == '1) begin
                blank_run++;
                if (sb.size() > 0) chk("blank_seg", 32'(seg), 32'h0);
            end else begin
                if (prev_an == '1) begin
                    int k;
                    k = -1;
                    for (int b = 0; b < ND; b++) if (!an[b] && k < 0) k = b;
                    if (sb.size() > 0) begin
                        chk("an_onehot", 32'($countones(~an)), 32'd1);
                        if (after_lit) chk("blank_len", 32'(blank_run), 32'(BC));
                        for (int i = 0; i < sb.size(); i++) begin
                            if (sb[i].idx == k) begin
                                chk($sformatf("slot%0d_seg", k), 32'(seg), 32'(sb[i].seg));
                                sb.delete(i);
                                break;
                            end
                        end
                    end
                end
                blank_run = 0;
                after_lit = 1'b1;
            end
            prev_an = an;
        end
    end

    task automatic push_exp(input int t);
        for (int d = 0; d < ND; d++) sb.push_back('{d, vec_seg[t][d]});
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 300 && sb.size() > 0; c++) @(posedge clk);
        chk({nm, "_drained"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic load(input int t, input bit from_empty);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = vec_val[t];
        @(posedge clk); #1;
        chk("acc_ready", 32'(in_ready), 32'd0);
        chk("acc_busy", 32'(busy), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("conv_ready", 32'(in_ready), 32'd1);
        chk("conv_busy", 32'(busy), 32'd0);
        if (from_empty) chk("conv_an_off", 32'(an), 32'h1F);
        @(posedge clk); #1;
        if (an != '1) begin
            int k;
            k = 0;
            for (int b = ND - 1; b >= 0; b--) if (!an[b]) k = b;
            chk("latency_seg", 32'(seg), 32'(vec_seg[t][k]));
        end
        push_exp(t);
        drain($sformatf("val%0h", vec_val[t]));
    endtask

    initial begin
        vec_val[0] = 16'd1234; vec_seg[0] = '{7'h66, 7'h4F, 7'h5B, 7'h06, Z};
        vec_val[1] = 16'd0;    vec_seg[1] = '{7'h3F, Z, Z, Z, Z};
        vec_val[2] = 16'hFFFF; vec_seg[2] = '{7'h6D, 7'h4F, 7'h6D, 7'h6D, 7'h7D};
        vec_val[3] = 16'd100;  vec_seg[3] = '{7'h3F, 7'h3F, 7'h06, Z, Z};
        vec_val[4] = 16'd200;  vec_seg[4] = '{7'h3F, 7'h3F, 7'h5B, Z, Z};
        vec_val[5] = 16'd9999; vec_seg[5] = '{7'h6F, 7'h6F, 7'h6F, 7'h6F, Z};

        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'h1F);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_an_rel", 32'(an), 32'h1F);
        chk("rst_seg", 32'(seg), 32'h0);
        for (int c = 0; c < 5 * SD; c++) begin
            @(negedge clk);
            chk("empty_an", 32'(an), 32'h1F);
        end

        load(0, 1'b1);
        load(1, 1'b0);
        load(2, 1'b0);

        // Back-to-back with in_valid held
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = vec_val[3];
        @(posedge clk); #1;
        chk("b2b_acc1_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_data = vec_val[4];
        @(posedge clk); #1;
        chk("b2b_conv_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("b2b_acc2_ready", 32'(in_ready), 32'd0);
        chk("b2b_acc2_busy", 32'(busy), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        push_exp(4);
        drain("b2b_200");

        // Async reset during CONV
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = vec_val[5];
        @(posedge clk); #1;
        chk("r9999_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'h1F);
        chk("async_seg", 32'(seg), 32'h0);
        chk("async_ready", 32'(in_ready), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6 * SD; c++) begin
            @(negedge clk);
            chk("post_rst_an", 32'(an), 32'h1F);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
